ofm_byte_packer: RTL and testbench

// - Receiving end of the activation output stream: collects signed 8-bit quantized/ReLU'd
//   OFM bytes, packs LANES bytes per word, emits words with address + byte strobes to OFM buffer.
// - Sits between activation stage and OFM SRAM write port; one instance per output channel lane.
// - Tile-based: start pulse loads base address and byte count; done pulses after last word written.

---
 rtl/ofm_byte_packer.sv | 203 ++++++++++++++++++++
 tb/tb_ofm_byte_packer.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ofm_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : ofm_byte_packer
// Purpose  : Collects signed activation bytes and packs LANES bytes per word.
//            Each packed word leaves with its OFM buffer word address and
//            byte strobes. A start pulse begins a tile, and done pulses after
//            the tile's last word has been written.
// Options  : OFM_ZERO_COUNT_EN adds the zero_count output, which counts the
//            accepted zero bytes in the current tile.
// Revision : 1.0 - initial release
// ============================================================================
module ofm_byte_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [CNT_WIDTH-1:0]             tile_bytes,
    input  logic                             in_valid,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             in_ready,
    output logic                             out_valid,
    output logic [WORD_WIDTH-1:0]            out_data,
    output logic [WORD_WIDTH/DATA_WIDTH-1:0] out_strb,
    output logic [ADDR_WIDTH-1:0]            out_addr,
    input  logic                             out_ready,
    output logic                             busy,
    output logic                             done
`ifdef OFM_ZERO_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]             zero_count
`endif
);

    localparam int LANES = WORD_WIDTH / DATA_WIDTH;
    localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PACK  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_busy;
    logic                    r_done;
    logic [CNT_WIDTH-1:0]    r_remaining;
    logic [PTR_W-1:0]        r_ptr;
    logic [WORD_WIDTH-1:0]   r_acc;
    logic [LANES-1:0]        r_strb;
    logic                    r_out_valid;
    logic [WORD_WIDTH-1:0]   r_out_data;
    logic [LANES-1:0]        r_out_strb;
    logic [ADDR_WIDTH-1:0]   r_out_addr;

    logic                    w_start_ok;
    logic                    w_out_stall;
    logic                    w_out_fire;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_last_byte;
    logic                    w_word_done;
    logic [WORD_WIDTH-1:0]   w_acc_next;
    logic [LANES-1:0]        w_strb_next;

    assign w_start_ok  = start & (r_state == S_IDLE);
    assign w_out_stall = r_out_valid & ~out_ready;
    assign w_out_fire  = r_out_valid & out_ready;
    // A pending, stalled word blocks intake, so the output register is never overwritten
    assign w_in_ready  = (r_state == S_PACK) & ~w_out_stall;
    assign w_accept    = in_valid & w_in_ready;
    assign w_last_byte = (r_remaining == CNT_WIDTH'(1));
    assign w_word_done = w_accept & (w_last_byte | (r_ptr == PTR_W'(LANES - 1)));

    // Merge the incoming byte into its lane; this is the word as it stands after this accept
    always_comb begin
        w_acc_next  = r_acc;
        w_strb_next = r_strb;
        for (int i = 0; i < LANES; i++) begin
            if (r_ptr == PTR_W'(i)) begin
                w_acc_next[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
                w_strb_next[i]                         = 1'b1;
            end
        end
    end

    // Tile control FSM with registered busy/done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_remaining <= tile_bytes;
                        r_busy      <= 1'b1;
                        if (tile_bytes != '0) begin
                            r_state <= S_PACK;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_PACK: begin
                    if (w_accept) begin
                        r_remaining <= r_remaining - CNT_WIDTH'(1);
                        if (w_last_byte) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Byte accumulation, output word register and word address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_strb      <= '0;
            r_ptr       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_strb  <= '0;
            r_out_addr  <= '0;
        end else begin
            if (w_start_ok) begin
                r_out_addr <= base_addr;
                r_acc      <= '0;
                r_strb     <= '0;
                r_ptr      <= '0;
            end else if (w_out_fire) begin
                r_out_addr <= r_out_addr + ADDR_WIDTH'(1);
            end

            if (w_word_done) begin
                // Completed word goes straight to the output register; unfilled lanes stay zero
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_next;
                r_out_strb  <= w_strb_next;
                r_acc       <= '0;
                r_strb      <= '0;
                r_ptr       <= '0;
            end else begin
                if (w_out_fire) begin
                    r_out_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_acc  <= w_acc_next;
                    r_strb <= w_strb_next;
                    r_ptr  <= r_ptr + PTR_W'(1);
                end
            end
        end
    end

`ifdef OFM_ZERO_COUNT_EN
    logic [CNT_WIDTH-1:0] r_zero_count;

    // Saturating count of zero bytes accepted in the current tile
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_count <= '0;
        end else if (w_start_ok) begin
            r_zero_count <= '0;
        end else if (w_accept && (in_data == '0) && (r_zero_count != '1)) begin
            r_zero_count <= r_zero_count + CNT_WIDTH'(1);
        end
    end

    assign zero_count = r_zero_count;
`endif

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_strb  = r_out_strb;
    assign out_addr  = r_out_addr;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ofm_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofm_byte_packer
// Purpose  : Directed, self-checking bench for ofm_byte_packer. It covers
//            packing, partial last word, backpressure, the empty tile, start
//            while busy, mid-tile reset and, when enabled, zero counting.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofm_byte_packer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [15:0] tile_bytes;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic [3:0]  out_strb;
    logic [11:0] out_addr;
    logic        out_ready;
    logic        busy;
    logic        done;
`ifdef OFM_ZERO_COUNT_EN
    logic [15:0] zero_count;
`endif

    ofm_byte_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .tile_bytes (tile_bytes),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_strb   (out_strb),
        .out_addr   (out_addr),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
`ifdef OFM_ZERO_COUNT_EN
        ,
        .zero_count (zero_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          last_hs = 0;
    int          n_done  = 0;
    logic [31:0] cap_data[$];
    logic [11:0] cap_addr[$];
    logic [3:0]  cap_strb[$];
    logic [7:0]  fq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every word handshake and every done pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                cap_data.push_back(out_data);
                cap_addr.push_back(out_addr);
                cap_strb.push_back(out_strb);
                last_hs <= cyc;
            end
            if (done) n_done <= n_done + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        cap_data.delete();
        cap_addr.delete();
        cap_strb.delete();
        n_done = 0;
    endtask

    task automatic fill_seq(input logic [7:0] first, input logic [7:0] step, input int n);
        logic [7:0] v;
        fq.delete();
        v = first;
        for (int i = 0; i < n; i++) begin
            fq.push_back(v);
            v = v + step;
        end
    endtask

    task automatic do_start(input logic [11:0] b, input logic [15:0] n);
        base_addr  = b;
        tile_bytes = n;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer the bytes in fq in order; a byte advances only when accepted
    task automatic feed();
        int  k = 0;
        int  g = 0;
        logic acc;
        if (fq.size() == 0) return;
        in_valid = 1'b1;
        in_data  = fq[0];
        while (k < fq.size() && g < 300) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                if (k < fq.size()) in_data = fq[k];
                else in_valid = 1'b0;
            end
            g++;
        end
        in_valid = 1'b0;
        chk("feed_all_accepted", k, fq.size());
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("done_seen", done, 1'b1);
        chk("done_after_hs", cyc, last_hs + 1);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
        chk("busy_low_after", busy, 1'b0);
    endtask

    task automatic expect_word(input int idx, input logic [31:0] d, input logic [11:0] a,
                               input logic [3:0] s);
        if (idx < cap_data.size()) begin
            chk("word_data", cap_data[idx], d);
            chk("word_addr", {20'd0, cap_addr[idx]}, {20'd0, a});
            chk("word_strb", {28'd0, cap_strb[idx]}, {28'd0, s});
        end else begin
            chk("word_missing", cap_data.size(), idx + 1);
        end
    endtask

    // Hold out_ready low for five cycles of the first pending word
    task automatic stall_first();
        int g = 0;
        out_ready = 1'b0;
        while (!out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("bp_valid_seen", out_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_data", out_data, 32'h14131211);
            chk("bp_hold_addr", {20'd0, out_addr}, 32'h100);
            chk("bp_in_ready_low", in_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        tile_bytes = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_out_addr", {20'd0, out_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two full words, no backpressure
        clear_log();
        do_start(12'h010, 16'd8);
        chk("busy_in_tile", busy, 1'b1);
        fill_seq(8'h01, 8'h01, 8);
        feed();
        wait_done();
        chk("t8_words", cap_data.size(), 2);
        expect_word(0, 32'h04030201, 12'h010, 4'hF);
        expect_word(1, 32'h08070605, 12'h011, 4'hF);

        // Partial last word
        @(posedge clk);
        #1;
        clear_log();
        do_start(12'h020, 16'd6);
        fill_seq(8'h01, 8'h01, 6);
        feed();
        wait_done();
        chk("t6_words", cap_data.size(), 2);
        expect_word(0, 32'h04030201, 12'h020, 4'hF);
        expect_word(1, 32'h00000605, 12'h021, 4'h3);

        // Backpressure on the first word of a 12-byte tile
        @(posedge clk);
        #1;
        clear_log();
        do_start(12'h100, 16'd12);
        fill_seq(8'h11, 8'h01, 12);
        fork
            feed();
            stall_first();
        join
        wait_done();
        chk("bp_words", cap_data.size(), 3);
        expect_word(0, 32'h14131211, 12'h100, 4'hF);
        expect_word(1, 32'h18171615, 12'h101, 4'hF);
        expect_word(2, 32'h1C1B1A19, 12'h102, 4'hF);

        // Empty tile: done next cycle, no word
        @(posedge clk);
        #1;
        clear_log();
        do_start(12'h3FF, 16'd0);
        chk("empty_done", done, 1'b1);
        chk("empty_no_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("empty_done_drop", done, 1'b0);
        chk("empty_busy_low", busy, 1'b0);
        chk("empty_no_words", cap_data.size(), 0);

        // Start while packing is ignored
        @(posedge clk);
        #1;
        clear_log();
        do_start(12'h200, 16'd4);
        fill_seq(8'h21, 8'h01, 2);
        feed();
        do_start(12'h2AA, 16'd8);
        fill_seq(8'h23, 8'h01, 2);
        feed();
        wait_done();
        chk("ign_words", cap_data.size(), 1);
        expect_word(0, 32'h24232221, 12'h200, 4'hF);

        // Reset in the middle of a tile
        @(posedge clk);
        #1;
        clear_log();
        do_start(12'h050, 16'd8);
        fill_seq(8'h01, 8'h01, 3);
        feed();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_out_addr", {20'd0, out_addr}, 32'h0);
        chk("arst_out_data", out_data, 32'h0);
        chk("arst_out_strb", {28'd0, out_strb}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_no_done", n_done, 0);
        do_start(12'h060, 16'd4);
        fill_seq(8'hAA, 8'h11, 4);
        feed();
        wait_done();
        chk("arst_words", cap_data.size(), 1);
        expect_word(0, 32'hDDCCBBAA, 12'h060, 4'hF);

`ifdef OFM_ZERO_COUNT_EN
        // Zero counting and clear on the next start
        @(posedge clk);
        #1;
        clear_log();
        do_start(12'h070, 16'd4);
        fq.delete();
        fq.push_back(8'h00);
        fq.push_back(8'h05);
        fq.push_back(8'h00);
        fq.push_back(8'h00);
        feed();
        wait_done();
        chk("zc_at_done", {16'd0, zero_count}, 32'd3);
        do_start(12'h080, 16'd4);
        chk("zc_cleared", {16'd0, zero_count}, 32'd0);
        fill_seq(8'h01, 8'h01, 4);
        feed();
        wait_done();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
